// File: rtl/sc_io_pkg.sv
// Shared definitions for the UART transmitter: CPU register offsets,
// STATUS bit layout and the transmit FSM state encoding.
package sc_io_pkg;

  // Word offsets decoded from addr
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 3;
  localparam int STAT_CNT_W   = 3;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sc_fifo.sv
// Small first-word-fall-through FIFO. DEPTH must be a power of two (>= 2)
// so the pointers wrap naturally. A push while full is accepted only when a
// pop happens in the same cycle, which frees the slot being written.
module sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a FIFO through
// DATA, the FSM serialises them LSB first with one start and one stop bit.
module sc_uart_tx
  import sc_io_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          wr_data, wr_status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cnt_ext;
  logic          busy, baud_done;
  logic          unused_bits;

  assign wr_data     = sel & we & (addr == ADDR_DATA);
  assign wr_status   = sel & we & (addr == ADDR_STATUS);
  assign busy        = (state_q != ST_IDLE);
  assign irq         = fifo_empty & ~busy;
  assign tx          = tx_q;
  assign baud_done   = (baud_q == '0);
  assign cnt_ext     = 32'(fifo_count);
  assign unused_bits = ^{wdata[31:8], cnt_ext[31:STAT_CNT_W]};

  sc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (wr_data),
    .pop    (fifo_pop),
    .wdata  (wdata[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Sticky overflow: set by a push that the FIFO cannot accept
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && wdata[0])                ovf_d = 1'b0;
    if (wr_data && fifo_full && !fifo_pop)    ovf_d = 1'b1;
  end

  // Transmit FSM: every state lasts CLK_DIV cycles; tx is computed one
  // cycle ahead so the registered line changes exactly on bit boundaries
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = BAUD_MAX;
          bit_d    = 3'd0;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          // Chain straight into the next frame when data is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = BAUD_MAX;
            bit_d    = 3'd0;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counters, shift register and line driver; reset forces tx high at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Register read mux; only STATUS returns data
  always_comb begin
    rdata = '0;
    if (addr == ADDR_STATUS) begin
      rdata[STAT_BUSY]                    = busy;
      rdata[STAT_FULL]                    = fifo_full;
      rdata[STAT_OVF]                     = ovf_q;
      rdata[STAT_CNT_LSB +: STAT_CNT_W]   = cnt_ext[STAT_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_sc_uart_tx.sv
// Directed bench for sc_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_sc_uart_tx;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic        sel    = 1'b0;
  logic        we     = 1'b0;
  logic [1:0]  addr   = 2'd0;
  logic [31:0] wdata  = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sc_uart_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .sel    (sel),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .tx     (tx),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU store; returns 1ns after the clock edge that captured it
  task automatic write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clock); #1;
    sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = 2'd1;
    #1;
    v = rdata;
    addr = 2'd0;
  endtask

  // Checks one 40-cycle frame slot by slot, starting at slot 'first'
  task automatic check_frame(input logic [7:0] b, input int first, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = first; k < 40; k++) begin
      check($sformatf("%s slot%0d", tag, k), 32'(tx), 32'(f[k/4]));
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 32'(irq), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    int bad;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst tx", 32'(tx), 32'h1);
    check("rst irq", 32'(irq), 32'h1);
    read_status(st);
    check("rst status", st, 32'h0);
    @(negedge clock) resetn = 1'b1;
    @(posedge clock); #1;
    check("post-rst tx", 32'(tx), 32'h1);
    read_status(st);
    check("post-rst status", st, 32'h0);

    // Single frame 0x55
    write(2'd0, 32'h55);
    check("f55 still idle", 32'(tx), 32'h1);
    check("f55 irq low", 32'(irq), 32'h0);
    read_status(st);
    check("f55 queued", st, 32'h08);
    @(posedge clock); #1;
    check_frame(8'h55, 0, "f55");
    read_status(st);
    check("f55 done status", st, 32'h0);
    check("f55 done irq", 32'(irq), 32'h1);
    check("f55 done tx", 32'(tx), 32'h1);

    // Three back-to-back frames
    write(2'd0, 32'h01);
    write(2'd0, 32'h02);
    read_status(st);
    check("b2b status after pop", st, 32'h09);
    check("b2b f01 slot0", 32'(tx), 32'h0);
    write(2'd0, 32'h03);
    read_status(st);
    check("b2b count2", st, 32'h11);
    check_frame(8'h01, 1, "b2b f01");
    check_frame(8'h02, 0, "b2b f02");
    check_frame(8'h03, 0, "b2b f03");
    read_status(st);
    check("b2b done status", st, 32'h0);

    // Overflow: six writes while idle
    for (int i = 0; i < 6; i++) write(2'd0, 32'hA0 + 32'(i));
    read_status(st);
    check("ovf status", st, 32'h27);
    check("ovf irq", 32'(irq), 32'h0);
    write(2'd2, 32'hFFFF_FFFF);
    write(2'd3, 32'hFFFF_FFFF);
    read_status(st);
    check("ovf reserved writes", st, 32'h27);
    write(2'd1, 32'h1);
    read_status(st);
    check("ovf cleared", st, 32'h23);
    wait_idle(300, "ovf drain");
    read_status(st);
    check("ovf drained status", st, 32'h0);

    // Reserved and DATA reads, reserved writes while idle
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        if (a != 1) begin
          sel = s[0]; addr = 2'(a);
          #1;
          check($sformatf("rd sel%0d addr%0d", s, a), rdata, 32'h0);
        end
      end
    end
    sel = 1'b0; addr = 2'd0;
    write(2'd2, 32'hFF);
    read_status(st);
    check("wr addr2 idle", st, 32'h0);
    write(2'd3, 32'hFFFF_FFFF);
    read_status(st);
    check("wr addr3 idle", st, 32'h0);
    check("wr reserved tx", 32'(tx), 32'h1);

    // Full FIFO, push coincident with STOP->START pop
    for (int i = 0; i < 5; i++) write(2'd0, 32'hC1 + 32'(i));
    read_status(st);
    check("full before", st, 32'h23);
    repeat (36) @(posedge clock);
    #1;
    check("full stop bit", 32'(tx), 32'h1);
    read_status(st);
    check("full at stop", st, 32'h23);
    write(2'd0, 32'hC6);
    check("full new start", 32'(tx), 32'h0);
    read_status(st);
    check("full push+pop", st, 32'h23);
    wait_idle(400, "full drain");
    read_status(st);
    check("full drained", st, 32'h0);

    // Reset in the middle of data bit 3 of 0xF0
    write(2'd0, 32'hF0);
    repeat (18) @(posedge clock);
    #1;
    check("rst mid bit3", 32'(tx), 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("rst async tx", 32'(tx), 32'h1);
    check("rst async irq", 32'(irq), 32'h1);
    read_status(st);
    check("rst async status", st, 32'h0);
    @(negedge clock) resetn = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (tx !== 1'b1) bad++;
    end
    check("no resume", 32'(bad), 32'h0);
    read_status(st);
    check("after rst status", st, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_uart_tx.md
SC_UART_TX -- requirements
Module: sc_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clock cycles per serial bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, a power of two.
REQ-003 SHALL have port clock  input  1  the single system clock, all state on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel  input  1  high when the hub decodes a CPU access to this peripheral.
REQ-006 SHALL have port addr  input  2  word offset: 0 = DATA, 1 = STATUS, 2/3 reserved.
REQ-007 SHALL have port wdata  input  32  CPU store data.
REQ-008 SHALL have port we  input  1  CPU store strobe, sampled only with sel.
REQ-009 SHALL have port rdata  output  32  read data, combinational from addr.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port irq  output  1  high while the FIFO is empty and the FSM is IDLE.

Function
REQ-012 A write with sel&we&addr==0 SHALL push wdata[7:0] into the FIFO on that clock edge.
REQ-013 A push to a full FIFO SHALL be discarded, leave the FIFO unchanged and set sticky overflow.
REQ-014 A write with sel&we&addr==1 and wdata[0]=1 SHALL clear overflow; a write to addr 2/3 SHALL have no effect.
REQ-015 STATUS read SHALL return {26'b0, count[2:0], overflow, full, busy} in bits [31:0] = {.., [5:3], [2], [1], [0]}.
REQ-016 DATA or reserved read SHALL return 0; rdata SHALL be independent of sel and we.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP; busy SHALL be 1 in every state except IDLE.
REQ-018 IDLE with FIFO non-empty SHALL pop one byte into the shift register and go to START at the next edge.
REQ-019 tx SHALL be 0 for exactly CLK_DIV cycles in START, starting the cycle after the pop.
REQ-020 DATA SHALL drive 8 bits, LSB first, each for exactly CLK_DIV cycles.
REQ-021 STOP SHALL drive tx=1 for CLK_DIV cycles, then go to IDLE, or straight to START with a new pop if the FIFO is non-empty, so back-to-back frames have no extra idle cycles.
REQ-022 The bit counter SHALL load CLK_DIV-1 on every bit boundary and count down to 0; its width SHALL be $clog2(CLK_DIV).
REQ-023 Push and pop in the same cycle SHALL both take effect, with count unchanged, including when the FIFO is full.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH, with full when count==FIFO_DEPTH.

Reset
REQ-025 While resetn=0: tx=1, state=IDLE, FIFO empty, overflow=0, bit and baud counters 0, irq=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame and drive tx high immediately, without waiting for a clock edge.
REQ-027 The first FSM action after reset release SHALL occur no earlier than the first rising edge with resetn=1.

Structure
REQ-028 Package sc_io_pkg SHALL hold the register offsets, the STATUS bit positions and the FSM state encoding.
REQ-029 The FIFO SHALL be the sub-module sc_fifo (parameterised width and depth, push/pop/full/empty/count).
REQ-030 The FSM, baud counter and shift register SHALL reside in sc_uart_tx.

Verification (bench with CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 Write 0x55 to DATA -> one cycle later tx=0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then tx=1 for 4 cycles; busy=0 and irq=1 afterwards.
REQ-032 Write 0x01, 0x02, 0x03 on consecutive cycles -> three 40-cycle frames with no idle gap between them; STATUS count reads 2 after the first pop.
REQ-033 Write six bytes back-to-back while idle -> the first pops immediately, four are queued, the sixth sets overflow; STATUS reads 0x27; writing 1 to STATUS then gives 0x23.
REQ-034 FIFO full, with a push in the same cycle as the STOP->START pop -> push accepted, count stays 4, overflow stays 0.
REQ-035 Assert resetn low at bit 3 of a frame -> tx=1 asynchronously, STATUS=0 after release, no partial frame resumes.
REQ-036 Read addr 0, 2 and 3 with sel=0 and sel=1 -> rdata=0; writes to addr 2/3 leave STATUS unchanged.
